// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative HI/LO
// multiply/divide unit.
//   muldiv_op_t    - request opcode as presented on req_op
//   muldiv_state_t - control FSM state, also exported for debug
//   DIV0_LO        - LO value produced by a divide by zero
//   MULDIV_ITERS   - iterations per operation (one result bit per cycle)
package muldiv_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    localparam logic [31:0] DIV0_LO      = 32'hFFFF_FFFF;
    localparam int          MULDIV_ITERS = 32;

    // Opcode encoding: bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic op_is_div(input muldiv_op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input muldiv_op_t op);
        return !op[0];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: purely combinational sign handling around the unsigned
// iteration datapath.
//   Accept side : is_signed, op1, op2 -> mag1, mag2 (magnitudes) and the
//                 result sign flags neg_res (product / quotient) and
//                 neg_rem (remainder, follows the dividend).
//   Fix side    : is_div, fix_neg_res, fix_neg_rem, raw (64-bit unsigned
//                 product or {remainder, quotient}) -> fix_hi, fix_lo.
module muldiv_signfix #(
    parameter int XLEN = 32
) (
    input  logic              is_signed,
    input  logic [XLEN-1:0]   op1,
    input  logic [XLEN-1:0]   op2,
    output logic [XLEN-1:0]   mag1,
    output logic [XLEN-1:0]   mag2,
    output logic              neg_res,
    output logic              neg_rem,
    input  logic              is_div,
    input  logic              fix_neg_res,
    input  logic              fix_neg_rem,
    input  logic [2*XLEN-1:0] raw,
    output logic [XLEN-1:0]   fix_hi,
    output logic [XLEN-1:0]   fix_lo
);

    logic              s1;
    logic              s2;
    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;

    // Unsigned ops never report a negative operand, so the sign flags are
    // zero for them and the fix side needs no opcode qualification.
    assign s1 = is_signed & op1[XLEN-1];
    assign s2 = is_signed & op2[XLEN-1];

    // abs(0x80000000) wraps to 0x80000000, which is the correct unsigned
    // magnitude; the DIV overflow case relies on this.
    assign mag1    = s1 ? -op1 : op1;
    assign mag2    = s2 ? -op2 : op2;
    assign neg_res = s1 ^ s2;
    assign neg_rem = s1;

    assign prod_fixed = fix_neg_res ? -raw : raw;
    assign quo_fixed  = fix_neg_res ? -raw[XLEN-1:0] : raw[XLEN-1:0];
    assign rem_fixed  = fix_neg_rem ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];

    assign fix_hi = is_div ? rem_fixed : prod_fixed[2*XLEN-1:XLEN];
    assign fix_lo = is_div ? quo_fixed : prod_fixed[XLEN-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI and LO.
//   clk, rst_n         - clock, asynchronous active-low reset
//   req_valid, req_op  - request strobe and opcode (muldiv_op_t encoding)
//   op1, op2           - multiplicand/dividend, multiplier/divisor;
//                        op1 is also the MTHI/MTLO source
//   req_ready, busy    - unit idle / unit computing (busy = !req_ready)
//   done               - one-cycle pulse after HI/LO take a result
//   wr_hi, wr_lo       - MTHI/MTLO strobes, honoured only while idle
//   hi, lo             - architectural HI/LO registers
//   dbg_state          - current FSM state
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; req_valid with req_ready low is dropped, never
// queued. The result lands 33 edges after the transfer edge.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ITERS = MULDIV_ITERS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic [1:0]      req_op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            req_ready,
    output logic            busy,
    output logic            done,
    input  logic            wr_hi,
    input  logic            wr_lo,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output muldiv_state_t   dbg_state
);

    muldiv_state_t     state;
    muldiv_state_t     state_next;
    muldiv_op_t        op_in;
    muldiv_op_t        op_q;
    logic [XLEN-1:0]   b_q;        // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] dp;         // {acc, multiplier} or {rem, quo}
    logic [2*XLEN-1:0] dp_next;
    logic [5:0]        cnt;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic              div0_q;
    logic              last_iter;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              neg_res_in;
    logic              neg_rem_in;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     trial;

    assign op_in     = muldiv_op_t'(req_op);
    assign req_ready = (state == IDLE);
    assign busy      = !req_ready;
    assign dbg_state = state;
    assign last_iter = (cnt == 6'(ITERS - 1));

    muldiv_signfix #(.XLEN(XLEN)) u_signfix (
        .is_signed   (op_is_signed(op_in)),
        .op1         (op1),
        .op2         (op2),
        .mag1        (mag1),
        .mag2        (mag2),
        .neg_res     (neg_res_in),
        .neg_rem     (neg_rem_in),
        .is_div      (op_is_div(op_q)),
        .fix_neg_res (neg_res_q),
        .fix_neg_rem (neg_rem_q),
        .raw         (dp),
        .fix_hi      (fix_hi),
        .fix_lo      (fix_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One iteration step. The multiply adds into a 33-bit accumulator so
    // the carry shifts into bit 63. The divide trial-subtracts from the
    // 33-bit {rem, next dividend bit}; bit 32 of the difference is the
    // borrow. With a zero divisor every trial succeeds, giving an all-ones
    // quotient and a remainder equal to the dividend magnitude.
    always_comb begin
        mul_sum = {1'b0, dp[2*XLEN-1:XLEN]} + (dp[0] ? {1'b0, b_q} : '0);
        trial   = dp[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        dp_next = {mul_sum, dp[XLEN-1:1]};
        if (op_is_div(op_q)) begin
            if (!trial[XLEN]) dp_next = {trial[XLEN-1:0], dp[XLEN-2:0], 1'b1};
            else              dp_next = {dp[2*XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= MULT;
            b_q       <= '0;
            dp        <= '0;
            cnt       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    op_q      <= op_in;
                    b_q       <= op_is_div(op_in) ? mag2 : mag1;
                    dp        <= {{XLEN{1'b0}}, (op_is_div(op_in) ? mag1 : mag2)};
                    cnt       <= '0;
                    neg_res_q <= neg_res_in;
                    neg_rem_q <= neg_rem_in;
                    div0_q    <= op_is_div(op_in) && (op2 == '0);
                end
                CALC: begin
                    dp  <= dp_next;
                    cnt <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // HI from the sign-fixed remainder already equals the latched op1 on
    // a divide by zero; only LO needs the forced all-ones value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= fix_hi;
            lo <= div0_q ? DIV0_LO : fix_lo;
        end else if (state == IDLE) begin
            if (wr_hi) hi <= op1;
            if (wr_lo) lo <= op1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b0;
        else        done <= (state == FIX);
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Stimulus tasks push
// the expected {hi, lo} and completion cycle of each request; a negedge
// monitor pops and compares on every done pulse and checks that HI/LO
// match the bench's own model of the architectural registers while busy.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'd0;
  logic [31:0]   op1 = '0;
  logic [31:0]   op2 = '0;
  logic          wr_hi = 1'b0;
  logic          wr_lo = 1'b0;
  logic          req_ready;
  logic          busy;
  logic          done;
  logic [31:0]   hi;
  logic [31:0]   lo;
  muldiv_state_t dbg_state;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  logic [63:0] exp_q[$];
  int          exp_c_q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] mon_e;
  int          mon_c;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .op1       (op1),
    .op2       (op2),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    p = '0;
    case (op)
      2'd0: p = 64'(sa * sb);
      2'd1: p = 64'(ua * ub);
      default: begin
        if (b == 32'd0) begin
          q = 32'hFFFF_FFFF;
          r = a;
        end else if (op == 2'd2) begin
          q = 32'(sa / sb);
          r = 32'(sa % sb);
        end else begin
          q = 32'(ua / ub);
          r = 32'(ua % ub);
        end
        p = {r, q};
      end
    endcase
    return p;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) chk("hold_hilo", {hi, lo}, {m_hi, m_lo});
      if (done) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_done: done=1 at cycle %0d, expected no pending result", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          mon_c = exp_c_q.pop_front();
          chk("result", {hi, lo}, mon_e);
          chk("latency", 64'(cyc), 64'(mon_c));
          {m_hi, m_lo} = mon_e;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: req_ready=%b, expected 1", req_ready);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic whi = 1'b0, input logic wlo = 1'b0);
    wait_ready();
    req_valid = 1'b1;
    req_op = op;
    op1 = a;
    op2 = b;
    wr_hi = whi;
    wr_lo = wlo;
    @(posedge clk);
    #1;
    if (whi) m_hi = a;
    if (wlo) m_lo = a;
    exp_q.push_back(ref_model(op, a, b));
    exp_c_q.push_back(cyc + 33);
    @(negedge clk);
    req_valid = 1'b0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
  endtask

  task automatic wait_done(output int t);
    int n = 0;
    t = -1;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    if (done) t = cyc;
    else begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", done, n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int t1;
    int t2;
    logic [31:0] v;

    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // directed vectors, also checked against literal expectations
    issue(MULT, 32'hFFFF_FFFF, 32'd2);
    wait_done(t1);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    issue(MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_done(t1);
    chk("multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(t1);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(t1);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
    issue(DIVU, 32'd7, 32'd0);
    wait_done(t1);
    chk("divu_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    issue(DIV, 32'hFFFF_FFF9, 32'd0);
    wait_done(t1);
    chk("div_zero_neg", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);

    // MTLO / MTHI in IDLE
    wr_lo = 1'b1;
    op1 = 32'h0000_1234;
    @(posedge clk);
    #1;
    wr_lo = 1'b0;
    m_lo = 32'h0000_1234;
    @(negedge clk);
    chk("mtlo", 64'(lo), 64'h1234);
    chk("mtlo_hi_keep", 64'(hi), 64'(m_hi));
    v = $urandom;
    wr_hi = 1'b1;
    wr_lo = 1'b1;
    op1 = v;
    @(posedge clk);
    #1;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    m_hi = v;
    m_lo = v;
    @(negedge clk);
    chk("mthi_mtlo", {hi, lo}, {v, v});

    // ignored request and MTHI while busy; write coincident with accept
    issue(MULTU, $urandom, $urandom, 1'b1, 1'b0);
    req_valid = 1'b1;
    req_op = DIVU;
    op1 = $urandom;
    op2 = $urandom;
    wr_hi = 1'b1;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    wr_hi = 1'b0;
    wait_done(t1);
    repeat (40) @(negedge clk);

    // reset in the middle of CALC
    issue(MULT, $urandom, $urandom);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    exp_c_q.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_idle", 64'(dbg_state), 64'(IDLE));
    issue(MULTU, 32'd3, 32'd5);
    wait_done(t1);
    chk("multu_3x5", 64'(lo), 64'd15);

    // back-to-back: next request issued in the done cycle
    issue(DIV, $urandom, pick());
    wait_done(t1);
    issue(MULT, $urandom, $urandom);
    wait_done(t2);
    chk("b2b_gap", 64'(t2 - t1), 64'd34);

    // randomized operations
    for (int i = 0; i < 30; i++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick());
      wait_done(t1);
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative HI/LO multiply/divide unit serving the MIPS datapath ALU. Accepts one MULT/MULTU/DIV/DIVU request at a time with a fixed 33-cycle latency, and owns the architectural HI and LO registers. Also handles MTHI/MTLO writes. While busy it holds HI/LO stable and asserts `busy` so control can interlock MFHI/MFLO and new requests.

## Interface
- `XLEN`, 32: operand and HI/LO width; only 32 is supported.
- `ITERS`, 32: iteration count; must equal `XLEN`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_valid`  in  1  request strobe; sampled only when `req_ready` is 1.
- `req_op`  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- `op1`  in  32  multiplicand or dividend; also the MTHI/MTLO source.
- `op2`  in  32  multiplier or divisor.
- `req_ready`  out  1  high exactly when the unit is in IDLE.
- `busy`  out  1  equals `!req_ready`.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO receive a result.
- `wr_hi`, `wr_lo`  in  1 each  MTHI/MTLO strobes; write `op1`.
- `hi`, `lo`  out  32 each  registered architectural HI/LO.

## Operation
- States are IDLE, CALC and FIX.
- **IDLE → CALC** when `req_valid` is high in IDLE:
  - Latch the op.
  - Latch operand magnitudes: abs value for signed ops, raw value for unsigned ops.
  - Latch the result sign flags.
  - Clear the 6-bit iteration counter.
- **CALC**: one iteration per cycle for 32 cycles, then go to FIX.
  - Multiply: shift-add on a 64-bit {acc, multiplier} register.
  - Divide: restoring; shift {rem, quo} left, trial-subtract divisor, set quotient bit if remainder is non-negative.
- **FIX**: apply signs, write HI/LO, then return to IDLE with `done` = 1 for the next cycle.
  - Signed multiply: negate the 64-bit product if operand signs differ.
  - Signed divide: quotient is negative if the signs differ; the remainder takes the dividend's sign.
  - Result placement: multiply writes HI = product[63:32], LO = product[31:0]; divide writes LO = quotient, HI = remainder.
- **Divide by zero** (`op2` == 0 at accept): same latency; LO = 0xFFFFFFFF and HI = `op1` as latched, for both DIV and DIVU.
- **DIV overflow**: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, which falls out naturally from magnitude arithmetic.
- **MTHI/MTLO**:
  - Honoured only in IDLE; ignored in CALC and FIX, because control must stall on `busy`.
  - `wr_hi` and `wr_lo` together write both registers.
  - A write coincident with an accepted request is applied; the result later overwrites HI/LO.
- `req_valid` while busy is ignored: no queueing, no error.

## Timing
- Reset (async, `rst_n` = 0) forces:
  - state IDLE; `hi` = 0, `lo` = 0.
  - `done` = 0, `req_ready` = 1, `busy` = 0.
  - counter and datapath registers cleared.
- Reset mid-operation aborts the operation immediately; no partial result is written.
- Latency:
  - Request accepted at edge N.
  - CALC edges N+1..N+32.
  - HI/LO written at edge N+33; `done` high in cycle N+33..N+34.
  - `req_ready` returns high after edge N+33.
- Back-to-back: a new request may be accepted in the same cycle `done` is high; throughput is one op per 34 cycles.
- `hi`/`lo` never change during CALC. MFHI/MFLO read them combinationally off the register outputs.

## Structure
- `muldiv_pkg` holds:
  - `muldiv_op_t` enum (MULT, MULTU, DIV, DIVU).
  - `muldiv_state_t` enum (IDLE, CALC, FIX).
  - constants `DIV0_LO` = 32'hFFFFFFFF and `MULDIV_ITERS` = 32.
- One combinational sub-module, `muldiv_signfix`, performs:
  - operand abs/sign extraction at accept;
  - 64-bit product and quotient/remainder negation in FIX.
- The FSM, counter and iteration datapath stay in `muldiv_unit`.

## Test plan
- **Signed multiply:** MULT `op1` = 0xFFFFFFFF, `op2` = 2 → after 33 cycles HI = 0xFFFFFFFF, LO = 0xFFFFFFFE, one `done` pulse. The same operands with MULTU → HI = 0x00000001, LO = 0xFFFFFFFE.
- **Signed divide:** DIV -7 (0xFFFFFFF9) / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero:** DIVU 7 / 0 → LO = 0xFFFFFFFF, HI = 0x00000007, latency still 33.
- **Handshake:**
  - A second `req_valid` during CALC is ignored.
  - A `wr_hi` during CALC is ignored; HI/LO hold their pre-op values until edge N+33.
  - In IDLE, `wr_lo` with `op1` = 0x1234 → LO = 0x1234 the next cycle.
- **Reset mid-op:** drop `rst_n` at CALC iteration 10 → `hi` = `lo` = 0, `req_ready` = 1 immediately, no `done`. After release, a new MULTU 3 × 5 gives LO = 15.
- **Back-to-back:** issue the next request in the `done` cycle → accepted, and its result lands exactly 34 cycles after the first result.
